freq_meter: RTL
===============

Name: freq_meter

Overview:
- Measures the frequency of a divided clock, such as the odd-ratio 50%-duty divider output, by counting its rising edges over a fixed gate window of system-clock cycles.
- Sits directly downstream of the clock divider: the divider output enters as a plain data signal and is sampled in the system clock domain. It is never used as a clock.
- The result is exposed for the board display / self-check logic, so the divider ratio and duty can be confirmed on hardware.

Parameters:
- GATE_CYCLES, 700, gate window length in clk cycles (>=2).
- CNT_W, 10, width of the edge counter and result.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous active-low reset.
- sig_in  input  1  signal under measurement (divider output), asynchronous to clk.
- start  input  1  single-cycle request to begin one measurement.
- abort  input  1  synchronous cancel of a running measurement.
- busy  output  1  high while a gate window is open.
- result  output  CNT_W  edge count of the last completed window.
- result_valid  output  1  one-cycle pulse when result updates.
- overflow  output  1  last completed window saturated the counter.

Behaviour:
- Reset is asynchronous and active-low on rst; clock is clk. While rst=0:
  - state=IDLE, busy=0, result=0, result_valid=0, overflow=0.
  - gate counter=0, edge counter=0, synchronizer flops=0.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - edge_pulse = s2 & ~s3.
  - Latency from an sig_in rise to edge_pulse is 2–3 clk cycles.
  - Exactly one pulse per rising edge; a high level never retriggers.
- FSM states: IDLE, GATE, DONE.
- IDLE:
  - busy=0.
  - start=1 moves to GATE next cycle; gate counter is loaded with 0 and edge counter is cleared.
- GATE:
  - busy=1 for exactly GATE_CYCLES consecutive cycles.
  - On each GATE cycle, edge_pulse=1 increments the edge counter.
  - The gate counter increments every cycle. On the cycle where gate counter == GATE_CYCLES-1 (edge still counted), move to DONE.
- DONE (one cycle):
  - result <= edge counter; overflow <= saturation flag; result_valid=1 for this single cycle.
  - busy=0; return to IDLE.
- Saturation:
  - The edge counter stops at 2^CNT_W-1 and does not wrap.
  - An edge arriving while the counter is at max sets the internal saturation flag.
  - The flag clears at gate start.
- start while busy=1, or in DONE: ignored. It is not queued.
- start in the same cycle as DONE's return is not possible, because DONE always passes through IDLE. start in IDLE the cycle after DONE is accepted.
- abort:
  - In GATE: go to IDLE next cycle. result, overflow and result_valid are not updated.
  - In IDLE or DONE: no effect. DONE still completes.
  - abort and start together in IDLE: start wins.
- Reset mid-window: immediate return to reset values; no result_valid.
- result and overflow hold their values between measurements.

Decomposition:
- Shared package freq_meter_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_GATE=2'd1, ST_DONE=2'd2;
  - default GATE_CYCLES/CNT_W constants.
- One sub-module, sig_edge_sync, contains the 2-flop synchronizer, history flop and rising-edge pulse. It is reusable for other divider-output consumers.

Test Plan:
- Divide-by-7 at all phases: sig_in from a bench divide-by-7 of clk (50% duty), GATE_CYCLES=700, start at each of 7 phase offsets → each run gives result=100, overflow=0, result_valid exactly 1 cycle, busy high exactly 700 cycles.
- Constant input: sig_in held 0, then held 1 → result=0 in both cases. The 0→1 step before start is not counted; a step inside the window counts as 1.
- Saturation: CNT_W=4, sig_in divide-by-2 of clk (edge every 2 cycles), GATE_CYCLES=100 → result=15, overflow=1. The next measurement with sig_in=0 gives result=0, overflow=0.
- Abort: start, then abort at gate cycle 300 → busy falls next cycle, no result_valid, result keeps its previous value (100). A following start/measurement returns 100.
- Ignored start: pulse start during GATE and during DONE → window length stays exactly 700 cycles and no second measurement begins. start in IDLE one cycle after DONE is accepted.
- Async reset: assert rst low mid-GATE, not aligned to clk → all outputs 0 immediately, state IDLE. After release, a new start measures 100.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared constants for the divided-clock frequency meter: FSM encoding and
// default gate window / counter width.
package freq_meter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GATE = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int GATE_CYCLES_DEF = 700;
   localparam int CNT_W_DEF       = 10;

endpackage

// File: rtl/freq_meter_sig_edge_sync.sv
// Brings an asynchronous level into the clk domain and emits one clk-wide
// pulse per rising edge; usable by any consumer of the divider output.
module sig_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic edge_pulse
);

   logic s1;
   logic s2;
   logic s3;

   // NOTE: registers update with <= so every flop samples the pre-edge value
   // of its neighbour; blocking = here would collapse the chain into one flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // s1 may be metastable; only s2/s3 are consumed.
   assign edge_pulse = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of a divider output over a GATE_CYCLES-long window of
// clk and publishes the count with a one-cycle valid and a saturation flag.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = GATE_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic [CNT_W-1:0] result,
   output logic             result_valid,
   output logic             overflow
);

   localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic [1:0]       state;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic             sat;
   logic             edge_pulse;
   logic [CNT_W-1:0] cnt_next;
   logic             sat_next;

   sig_edge_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .edge_pulse (edge_pulse)
   );

   // NOTE: every output of this block gets a default before any condition,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      cnt_next = edge_cnt;
      sat_next = sat;
      if (edge_pulse) begin
         if (edge_cnt == CNT_MAX) sat_next = 1'b1;
         else                     cnt_next = edge_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_GATE;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end
            end
            ST_GATE: begin
               edge_cnt <= cnt_next;
               sat      <= sat_next;
               gate_cnt <= gate_cnt + GW'(1);
               if (abort) begin
                  state <= ST_IDLE;
               end else if (gate_cnt == GATE_LAST) begin
                  // Load with the last cycle's edge included so result is
                  // already current while result_valid is high in DONE.
                  state    <= ST_DONE;
                  result   <= cnt_next;
                  overflow <= sat_next;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy         = (state == ST_GATE);
   assign result_valid = (state == ST_DONE);

endmodule
